seg7_scan_driver: RTL and testbench

//   Parametrised binary-to-BCD converter plus time-multiplexed 7-segment display driver.

---
 rtl/seg7_scan_driver_if.sv | 14 +
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle for seg7_scan_driver: conversion request, status and latched BCD result.
interface seg7_scan_driver_if #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
);
  logic [IN_W-1:0]     bin_in;
  logic                load;
  logic                busy;
  logic [4*DIGITS-1:0] bcd_out;
  logic                overflow;

  modport master (output bin_in, load, input busy, bcd_out, overflow);
  modport slave  (input bin_in, load, output busy, bcd_out, overflow);
endinterface

// File: rtl/seg7_scan_driver.sv
// Sequential double-dabble binary-to-BCD converter with a multiplexed common-anode 7-seg scanner.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero blanking on the display.
//
// state | meaning
// IDLE  | waiting for load, result held
// SHIFT | IN_W add-3/shift iterations
// DONE  | latch result and display register
module seg7_scan_driver #(
  parameter int IN_W        = 14,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          cathode
);

  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic                start, shift_en, latch, busy;
  logic [CW-1:0]       cnt;
  logic [IN_W-1:0]     sh;
  logic [SW-1:0]       scr, scr_adj;
  logic [4*DIGITS-1:0] bcd_q, disp;
  logic                ovf_q, disp_ovf;
  logic [RW-1:0]       ref_cnt;
  logic [IW-1:0]       idx;
  logic [3:0]          cur_digit;
  logic [6:0]          seg_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = (state == IDLE) && bus.load;
    shift_en = (state == SHIFT);
    latch    = (state == DONE);
    busy     = (state != IDLE);
  end

  always_comb begin
    scr_adj = scr;
    for (int i = 0; i <= DIGITS; i++) begin
      if (scr[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh       <= '0;
      scr      <= '0;
      cnt      <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      disp     <= '0;
      disp_ovf <= 1'b0;
    end else if (start) begin
      sh  <= bus.bin_in;
      scr <= '0;
      cnt <= CW'(IN_W - 1);
    end else if (shift_en) begin
      scr <= {scr_adj[SW-2:0], sh[IN_W-1]};
      sh  <= {sh[IN_W-2:0], 1'b0};
      if (cnt != '0) cnt <= cnt - CW'(1);
    end else if (latch) begin
      bcd_q    <= scr[4*DIGITS-1:0];
      ovf_q    <= (scr[SW-1 -: 4] != 4'd0);
      disp     <= scr[4*DIGITS-1:0];
      disp_ovf <= (scr[SW-1 -: 4] != 4'd0);
    end
  end

  assign bus.busy     = busy;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

  assign cur_digit = disp[{idx, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  logic shown;
  // A digit is shown if it or any more significant digit is nonzero; digit 0 always shown.
  always_comb begin
    shown = (idx == '0);
    for (int i = 0; i < DIGITS; i++) begin
      if ((IW'(i) >= idx) && (disp[4*i +: 4] != 4'd0)) shown = 1'b1;
    end
  end

  always_comb begin
    if (disp_ovf)   seg_nxt = 7'b1111110;
    else if (shown) seg_nxt = seg_decode(cur_digit);
    else            seg_nxt = 7'b1111111;
  end
`else
  always_comb begin
    if (disp_ovf) seg_nxt = 7'b1111110;
    else          seg_nxt = seg_decode(cur_digit);
  end
`endif

  // anode and cathode share one register stage so segments never lead the digit enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= '0;
      anode   <= '1;
      cathode <= 7'b1111111;
    end else begin
      if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        ref_cnt <= ref_cnt + RW'(1);
      end
      anode   <= ~(DIGITS'(1) << idx);
      cathode <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (IN_W=14, DIGITS=4, REFRESH_DIV=4).
module tb_seg7_scan_driver;
  localparam int IN_W = 14;
  localparam int DIGITS = 4;
  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DIGITS-1:0] anode;
  logic [6:0] cathode;

  seg7_scan_driver_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(.IN_W(IN_W), .DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .bus(bus), .anode(anode), .cathode(cathode)
  );

  always #5 clk = ~clk;

  typedef struct { logic [13:0] bin; logic [15:0] bcd; logic ovf; } vec_t;
  typedef struct { logic [15:0] bcd; logic ovf; } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_bcd = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] cath_model(input logic [15:0] bcd, input logic ovf, input int i);
    if (ovf) return 7'b1111110;
`ifdef SEG7_LZ_BLANK_EN
    if (i != 0 && (bcd >> (4 * i)) == 16'h0) return 7'b1111111;
`endif
    return seg_ref(bcd[4*i +: 4]);
  endfunction

  // Accept a load in the current (idle) cycle, track busy, then pop the scoreboard.
  task automatic convert(input logic [13:0] val, input logic [15:0] ebcd, input logic eovf);
    int n;
    exp_t e;
    n = 0;
    while (bus.busy && n < 40) begin n++; tick(); end
    if (bus.busy) chk("idle_wait_timeout", 1, 0);
    bus.bin_in = val;
    bus.load = 1'b1;
    sb.push_back('{bcd: ebcd, ovf: eovf});
    tick();
    bus.load = 1'b0;
    bus.bin_in = 14'h3fff;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (n == 2) chk("hold_prev_bcd", {16'h0, bus.bcd_out}, {16'h0, last_bcd});
      tick();
    end
    chk("busy_cycles", n, IN_W + 1);
    e = sb.pop_front();
    chk("bcd_out", {16'h0, bus.bcd_out}, {16'h0, e.bcd});
    chk("overflow", {31'h0, bus.overflow}, {31'h0, e.ovf});
    last_bcd = e.bcd;
  endtask

  task automatic scan_check(input logic [15:0] bcd, input logic ovf);
    int idx;
    for (int k = 0; k < RDIV * DIGITS; k++) begin
      tick();
      idx = 0;
      for (int i = 0; i < DIGITS; i++) if (!anode[i]) idx = i;
      chk("anode_onecold", $countones(~anode), 1);
      chk("cathode", {25'h0, cathode}, {25'h0, cath_model(bcd, ovf, idx)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
    vecs[1] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
    vecs[2] = '{bin: 14'd10000, bcd: 16'h0000, ovf: 1'b1};
    vecs[3] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
    vecs[4] = '{bin: 14'd7,     bcd: 16'h0007, ovf: 1'b0};
    vecs[5] = '{bin: 14'd16383, bcd: 16'h6383, ovf: 1'b1};
    vecs[6] = '{bin: 14'd100,   bcd: 16'h0100, ovf: 1'b0};
    vecs[7] = '{bin: 14'd5,     bcd: 16'h0005, ovf: 1'b0};

    bus.load = 1'b0;
    bus.bin_in = '0;
    tick(); tick();
    chk("rst_anode", {28'h0, anode}, 32'hf);
    chk("rst_cathode", {25'h0, cathode}, 32'h7f);
    chk("rst_busy", {31'h0, bus.busy}, 0);
    chk("rst_bcd", {16'h0, bus.bcd_out}, 0);
    chk("rst_ovf", {31'h0, bus.overflow}, 0);
    rst = 1'b0;

    // Scan order straight out of reset: digit 0 enabled on the first edge, RDIV cycles each.
    for (int k = 0; k < RDIV * DIGITS; k++) begin
      tick();
      chk("scan_seq", {28'h0, anode}, {28'h0, ~(4'b0001 << (k / RDIV))});
    end
    scan_check(16'h0000, 1'b0);

    for (int v = 0; v < 8; v++) begin
      convert(vecs[v].bin, vecs[v].bcd, vecs[v].ovf);
      scan_check(vecs[v].bcd, vecs[v].ovf);
    end

    // Back-to-back: second load lands in the first idle cycle after DONE.
    convert(14'd9999, 16'h9999, 1'b0);
    convert(14'd1234, 16'h1234, 1'b0);

    // Load while busy is ignored and not queued.
    bus.bin_in = 14'd42;
    bus.load = 1'b1;
    sb.push_back('{bcd: 16'h0042, ovf: 1'b0});
    tick();
    bus.bin_in = 14'd77;
    for (int k = 0; k < 3; k++) tick();
    bus.load = 1'b0;
    for (int k = 0; k < 40 && bus.busy; k++) tick();
    begin
      exp_t e;
      e = sb.pop_front();
      chk("busy_load_bcd", {16'h0, bus.bcd_out}, {16'h0, e.bcd});
      last_bcd = e.bcd;
    end
    tick(); tick();
    chk("busy_load_not_queued", {31'h0, bus.busy}, 0);

    // Reset during SHIFT cycle 6 leaves no partial result.
    bus.bin_in = 14'd5555;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, bus.busy}, 0);
    chk("midrst_bcd", {16'h0, bus.bcd_out}, 0);
    chk("midrst_anode", {28'h0, anode}, 32'hf);
    chk("midrst_cathode", {25'h0, cathode}, 32'h7f);
    tick();
    rst = 1'b0;
    last_bcd = 16'h0000;
    tick();
    convert(14'd0, 16'h0000, 1'b0);
    scan_check(16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
